ei_tdp_ram_core: RTL
====================

Name: ei_tdp_ram_core

Overview:
- Parametrised true dual-port synchronous RAM. Second generation of the TDP RAM design under test.
- Adds over the first generation:
  - per-port byte-lane write enables
  - configurable read latency
  - configurable same-port read/write mode
  - cross-port collision detection
  - per-port read-valid strobes
- Sits behind the TDP RAM UVC interface. Both ports run on one clock.

Parameters:
- ADDR_WIDTH, 10: address bits per port; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: word width; must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- READ_LATENCY, 1: cycles from read request to out_x; legal values 1 or 2.
- WRITE_MODE, 0: same-port simultaneous read+write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- resetn  in  1  synchronous, active-high reset (1 = reset asserted).
- we_a / we_b  in  1  write request, port A / B.
- re_a / re_b  in  1  read request, port A / B.
- be_a / be_b  in  BE_WIDTH  byte-lane write enables; bit i covers data[8i+7:8i].
- addr_a / addr_b  in  ADDR_WIDTH  word address.
- data_a / data_b  in  DATA_WIDTH  write data.
- out_a / out_b  out  DATA_WIDTH  read data.
- out_valid_a / out_valid_b  out  1  one-cycle strobe; out_x carries data for a read issued READ_LATENCY cycles earlier.
- collision  out  1  one-cycle pulse; cross-port same-address conflict seen on the previous edge.
- par_err_a / par_err_b  out  1  parity error strobes; present only with TDP_RAM_PARITY_EN.

Behaviour:
- Reset (resetn = 1 at posedge):
  - clears out_a, out_b, out_valid_a, out_valid_b, collision, par_err_a, par_err_b and all pipeline stages to 0.
  - Memory array contents are not cleared.
  - Requests sampled in a reset cycle are ignored.
  - Reads in flight when reset asserts are discarded; no valid strobe follows reset.
- Write:
  - we_x = 1 at posedge writes each byte lane with be_x[i] = 1.
  - Lanes with be_x[i] = 0 are unchanged.
  - we_x with be_x = 0 is a no-op.
- Read:
  - re_x = 1 at edge N: out_x and out_valid_x update at edge N + READ_LATENCY - 1. Latency 1 = registered output; latency 2 = one extra output register.
  - out_valid_x is high for exactly one cycle per read.
  - Back-to-back reads sustain one read per cycle per port.
  - re_x = 0: out_x holds its last value and out_valid_x = 0.
- Same-port we_x & re_x, same edge:
  - READ_FIRST: out_x returns the pre-write word.
  - WRITE_FIRST: out_x returns the merged post-write word.
  - NO_CHANGE: write occurs, the read is suppressed, out_valid_x stays 0 and out_x holds.
- Cross-port, same edge, addr_a == addr_b:
  - Both ports write: port A's enabled lanes win. Port B's lanes not enabled on A still land. collision = 1 next cycle.
  - One port writes, the other reads: the reader gets the pre-write word (read-before-write). collision = 1 next cycle.
  - Both ports read: no collision; both get the same data.
- Addresses index the full 2**ADDR_WIDTH range; there is no out-of-range condition.

Optional Feature:
- Macro: TDP_RAM_PARITY_EN.
- Defined:
  - Stores one even-parity bit per byte lane alongside the data, computed on write per enabled lane.
  - On read, recomputes parity. par_err_x = 1 aligned with out_valid_x if any lane mismatches; out_x still carries the stored data.
- Undefined: no parity storage; par_err_a and par_err_b are absent from the port list.

Test Plan:
- Reset then read: resetn high 2 cycles, release, re_a @addr 0x005 -> out_valid_a pulses once with READ_LATENCY timing; all outputs 0 during reset.
- Byte enables (DATA_WIDTH = 32): write 0xAABBCCDD be = 4'hF to 0x010, then 0x11223344 be = 4'b0101 -> read returns 0xAA22CC44.
- Same-port WRITE_MODE sweep: 0x3F0 holds 0x12; same-edge we_a/re_a with data 0x34 -> out_a = 0x12 (mode 0), 0x34 (mode 1), no valid and held out_a (mode 2).
- Dual write collision: we_a data 0x5A, we_b data 0xA5, both @0x100 -> memory holds 0x5A, collision pulses one cycle; different addresses -> no pulse.
- Write/read collision: 0x200 holds 0x77; we_a 0x88 and re_b same edge @0x200 -> out_b = 0x77, collision = 1; re_b next cycle -> 0x88.
- Reset mid-read at READ_LATENCY = 2: re_a issued, resetn asserted next edge -> no out_valid_a; memory still holds the previously written value afterwards.

Source files
------------

// File: rtl/ei_tdp_ram_core.sv
// True dual-port single-clock RAM: byte-lane writes, 1/2-cycle read latency, same-port write modes, collision flag.
// Optional per-lane even parity storage and check when TDP_RAM_PARITY_EN is defined.
module ei_tdp_ram_core #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      we_a,
    input  logic                      we_b,
    input  logic                      re_a,
    input  logic                      re_b,
    input  logic [DATA_WIDTH/8-1:0]   be_a,
    input  logic [DATA_WIDTH/8-1:0]   be_b,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [ADDR_WIDTH-1:0]     addr_b,
    input  logic [DATA_WIDTH-1:0]     data_a,
    input  logic [DATA_WIDTH-1:0]     data_b,
    output logic [DATA_WIDTH-1:0]     out_a,
    output logic [DATA_WIDTH-1:0]     out_b,
    output logic                      out_valid_a,
    output logic                      out_valid_b,
`ifdef TDP_RAM_PARITY_EN
    output logic                      par_err_a,
    output logic                      par_err_b,
`endif
    output logic                      collision
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic [DATA_WIDTH-1:0] wr_word_a, wr_word_b;
    logic                  fire_a, fire_b;
    logic                  same_addr;

    logic [DATA_WIDTH-1:0] s1_dat_a, s1_dat_b;
    logic                  s1_vld_a, s1_vld_b;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    assign old_a     = mem[addr_a];
    assign old_b     = mem[addr_b];
    assign same_addr = (addr_a == addr_b);

    always_comb begin
        fire_a    = re_a && !(WRITE_MODE == 2 && we_a);
        fire_b    = re_b && !(WRITE_MODE == 2 && we_b);
        rd_a      = (WRITE_MODE == 1 && we_a) ? merge_lanes(old_a, data_a, be_a) : old_a;
        rd_b      = (WRITE_MODE == 1 && we_b) ? merge_lanes(old_b, data_b, be_b) : old_b;
        wr_word_b = merge_lanes(old_b, data_b, be_b);
        // On a shared address, A's lanes are layered over B's so A wins while B's other lanes still land.
        wr_word_a = merge_lanes((same_addr && we_b) ? wr_word_b : old_a, data_a, be_a);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if (we_b) mem[addr_b] <= wr_word_b;
            if (we_a) mem[addr_a] <= wr_word_a;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            s1_vld_a  <= 1'b0;
            s1_vld_b  <= 1'b0;
            s1_dat_a  <= '0;
            s1_dat_b  <= '0;
            collision <= 1'b0;
        end else begin
            s1_vld_a  <= fire_a;
            s1_vld_b  <= fire_b;
            if (fire_a) s1_dat_a <= rd_a;
            if (fire_b) s1_dat_b <= rd_b;
            collision <= same_addr && ((we_a && (we_b || re_b)) || (we_b && re_a));
        end
    end

`ifdef TDP_RAM_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [DEPTH];
    logic [BE_WIDTH-1:0] old_par_a, old_par_b, rd_par_a, rd_par_b;
    logic [BE_WIDTH-1:0] wr_par_a, wr_par_b;
    logic                s1_err_a, s1_err_b;

    function automatic logic [BE_WIDTH-1:0] lane_par(input logic [DATA_WIDTH-1:0] w);
        logic [BE_WIDTH-1:0] p;
        for (int i = 0; i < BE_WIDTH; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    function automatic logic [BE_WIDTH-1:0] merge_par(
        input logic [BE_WIDTH-1:0] old_p,
        input logic [BE_WIDTH-1:0] new_p,
        input logic [BE_WIDTH-1:0] be
    );
        return (old_p & ~be) | (new_p & be);
    endfunction

    assign old_par_a = par_mem[addr_a];
    assign old_par_b = par_mem[addr_b];

    always_comb begin
        rd_par_a = (WRITE_MODE == 1 && we_a) ? merge_par(old_par_a, lane_par(data_a), be_a) : old_par_a;
        rd_par_b = (WRITE_MODE == 1 && we_b) ? merge_par(old_par_b, lane_par(data_b), be_b) : old_par_b;
        wr_par_b = merge_par(old_par_b, lane_par(data_b), be_b);
        wr_par_a = merge_par((same_addr && we_b) ? wr_par_b : old_par_a, lane_par(data_a), be_a);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if (we_b) par_mem[addr_b] <= wr_par_b;
            if (we_a) par_mem[addr_a] <= wr_par_a;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            s1_err_a <= 1'b0;
            s1_err_b <= 1'b0;
        end else begin
            s1_err_a <= fire_a && |(lane_par(rd_a) ^ rd_par_a);
            s1_err_b <= fire_b && |(lane_par(rd_b) ^ rd_par_b);
        end
    end
`endif

    if (READ_LATENCY == 1) begin : g_lat1
        assign out_a       = s1_dat_a;
        assign out_b       = s1_dat_b;
        assign out_valid_a = s1_vld_a;
        assign out_valid_b = s1_vld_b;
`ifdef TDP_RAM_PARITY_EN
        assign par_err_a   = s1_err_a;
        assign par_err_b   = s1_err_b;
`endif
    end else begin : g_lat2
        always_ff @(posedge clk) begin
            if (resetn) begin
                out_a       <= '0;
                out_b       <= '0;
                out_valid_a <= 1'b0;
                out_valid_b <= 1'b0;
            end else begin
                out_valid_a <= s1_vld_a;
                out_valid_b <= s1_vld_b;
                if (s1_vld_a) out_a <= s1_dat_a;
                if (s1_vld_b) out_b <= s1_dat_b;
            end
        end
`ifdef TDP_RAM_PARITY_EN
        always_ff @(posedge clk) begin
            if (resetn) begin
                par_err_a <= 1'b0;
                par_err_b <= 1'b0;
            end else begin
                par_err_a <= s1_err_a;
                par_err_b <= s1_err_b;
            end
        end
`endif
    end

endmodule
